// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared constants and hex-to-seven-segment lookup for the
//               output-port display logic.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int NUM_DIGITS  = 8;
    localparam int CTRL_EN_LSB = 0;
    localparam int CTRL_DP_LSB = 8;
    localparam int CTRL_LZB    = 16;

    // Active-low segment pattern, bit order g..a.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational 4-bit nibble to active-low seven-segment decode.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import io_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg7(i_nibble);

endmodule
`default_nettype wire

// File: rtl/io_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : io_seg7_scan
// Description : 8-digit multiplexed hex display driver with per-slot guard
//               blanking and frame-synchronous snapshot of the port words.
// Revision    : 1.0 - initial release
// ============================================================================
module io_seg7_scan
    import io_pkg::*;
#(
    parameter int DIV_COUNT = 50000,
    parameter int GUARD     = 500,
    parameter int CNT_W     = 16
)(
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] C_GUARD    = CNT_W'(GUARD);

    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_digit;
    logic              r_run;
    logic [31:0]       r_data_q;
    logic [CTRL_LZB:0] r_ctrl_q;

    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        w_digit_nxt;
    logic              w_snap;
    logic [31:0]       w_data_nxt;
    logic [CTRL_LZB:0] w_ctrl_nxt;
    logic [NUM_DIGITS-1:0] w_en_mask;
    logic [NUM_DIGITS-1:0] w_dp_mask;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg_dec;
    logic              w_upper_zero;
    logic              w_blank;
    logic              w_lit;
    logic              w_unused_ctrl;

    assign w_unused_ctrl = ^out_port1[31:CTRL_LZB+1];

    // r_run is clear only until the first edge after reset; that edge re-enters
    // (0,0) so the very first frame is snapshotted like every later one.
    always_comb begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_digit_nxt = r_digit;
        if (!r_run) begin
            w_cnt_nxt   = '0;
            w_digit_nxt = '0;
        end else if (r_cnt == C_CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_digit_nxt = r_digit + 3'd1;
        end
    end

    assign w_snap     = (w_digit_nxt == 3'd0) && (w_cnt_nxt == '0);
    assign w_data_nxt = w_snap ? out_port0 : r_data_q;
    assign w_ctrl_nxt = w_snap ? out_port1[CTRL_LZB:0] : r_ctrl_q;

    assign w_en_mask    = w_ctrl_nxt[CTRL_EN_LSB +: NUM_DIGITS];
    assign w_dp_mask    = w_ctrl_nxt[CTRL_DP_LSB +: NUM_DIGITS];
    assign w_nibble     = w_data_nxt[{w_digit_nxt, 2'b00} +: 4];
    assign w_upper_zero = ((w_data_nxt >> {w_digit_nxt, 2'b00}) == 32'd0);
    assign w_blank      = (w_digit_nxt != 3'd0) && w_ctrl_nxt[CTRL_LZB] && w_upper_zero;
    assign w_lit        = (w_cnt_nxt >= C_GUARD) && w_en_mask[w_digit_nxt] && !w_blank;

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            r_run      <= 1'b0;
            r_cnt      <= '0;
            r_digit    <= '0;
            r_data_q   <= '0;
            r_ctrl_q   <= '0;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_cnt      <= w_cnt_nxt;
            r_digit    <= w_digit_nxt;
            r_data_q   <= w_data_nxt;
            r_ctrl_q   <= w_ctrl_nxt;
            frame_tick <= w_snap;
            if (w_lit) begin
                an  <= ~(8'd1 << w_digit_nxt);
                seg <= w_seg_dec;
                dp  <= ~w_dp_mask[w_digit_nxt];
            end else begin
                an  <= 8'hFF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_seg7_scan
// Description : Directed and random bench for io_seg7_scan against a
//               frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_io_seg7_scan;

    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int CW    = 4;
    localparam int FRAME = 8 * DIV;

    logic        io_clk = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] out_port0 = 32'd0;
    logic [31:0] out_port1 = 32'd0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;
    int t_first  = 0;

    // Model: position within the 64-cycle frame plus the latched words.
    bit          m_run  = 1'b0;
    int          m_pos  = 0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_ctrl = 32'd0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    io_seg7_scan #(.DIV_COUNT(DIV), .GUARD(GRD), .CNT_W(CW)) dut (
        .io_clk     (io_clk),
        .reset      (reset),
        .out_port0  (out_port0),
        .out_port1  (out_port1),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial forever #5 io_clk = ~io_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h pos=%0d", tag, obs, exp, m_pos);
        end
    endtask

    task automatic check_all();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_ft;
        int         dig;
        int         cnt;
        bit         allz;
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
        if (m_run) begin
            dig  = m_pos / DIV;
            cnt  = m_pos % DIV;
            e_ft = (m_pos == 0);
            allz = 1'b1;
            for (int k = dig; k < 8; k++)
                if (m_data[4*k +: 4] != 4'd0) allz = 1'b0;
            if (cnt >= GRD && m_ctrl[dig] && !(dig > 0 && m_ctrl[16] && allz)) begin
                e_an  = ~(8'd1 << dig);
                e_seg = hex_tab[m_data[4*dig +: 4]];
                e_dp  = ~m_ctrl[8 + dig];
            end
            if (cnt < GRD) chk("guard_dark", an, 8'hFF);
        end
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("dp", dp, e_dp);
        chk("frame_tick", frame_tick, e_ft);
        chk("an_one_low", ($countones(~an) <= 1), 1);
    endtask

    task automatic tick();
        @(posedge io_clk);
        ncyc++;
        if (reset) begin
            m_run = 1'b0;
        end else begin
            if (!m_run) m_pos = 0;
            else        m_pos = (m_pos + 1) % FRAME;
            m_run = 1'b1;
            if (m_pos == 0) begin
                m_data = out_port0;
                m_ctrl = out_port1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic run_to(input int p);
        for (int k = 0; k <= FRAME; k++) begin
            tick();
            if (m_run && m_pos == p) return;
        end
        checks++;
        failures++;
        $display("FAIL run_to observed=timeout expected=pos%0d", p);
    endtask

    initial begin
        // Reset held with data already present on the ports
        out_port0 = 32'h12345678;
        out_port1 = 32'h000000FF;
        repeat (3) tick();
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        reset = 1'b0;

        tick();
        t_first = ncyc;
        chk("first_tick", frame_tick, 1'b1);
        chk("first_an", an, 8'hFF);
        run_to(2);
        chk("d0_an", an, 8'hFE);
        chk("d0_seg", seg, 7'h00);
        run_to(10);
        chk("d1_an", an, 8'hFD);
        chk("d1_seg", seg, 7'h78);
        run_to(58);
        chk("d7_an", an, 8'h7F);
        chk("d7_seg", seg, 7'h79);
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (frame_tick === 1'b1) break;
        end
        chk("frame_period", ncyc - t_first, FRAME);

        // Asynchronous reset at digit 3, cnt 5
        run_to(29);
        chk("pre_rst_an", an, 8'hF7);
        #2 reset = 1'b1;
        #1;
        m_run = 1'b0;
        chk("async_an", an, 8'hFF);
        chk("async_seg", seg, 7'h7F);
        chk("async_dp", dp, 1'b1);
        chk("async_ft", frame_tick, 1'b0);
        out_port0 = 32'h000000A0;
        out_port1 = 32'h000100FF;
        #1 reset = 1'b0;

        // Leading-zero blanking
        tick();
        chk("rel_tick", frame_tick, 1'b1);
        run_to(3);
        chk("lzb_d0_seg", seg, 7'h40);
        chk("lzb_d0_an", an, 8'hFE);
        run_to(10);
        chk("lzb_d1_seg", seg, 7'h08);
        chk("lzb_d1_an", an, 8'hFD);
        run_to(15);
        for (int k = 16; k < FRAME; k++) begin
            tick();
            chk("lzb_dark", an, 8'hFF);
        end

        // Mid-frame write must not tear the frame in progress
        out_port0 = 32'h11111111;
        out_port1 = 32'h000000FF;
        run_to(0);
        run_to(26);
        out_port0 = 32'h22222222;
        run_to(42);
        chk("tear_d5", seg, 7'h79);
        run_to(58);
        chk("tear_d7", seg, 7'h79);
        run_to(0);
        chk("tear_ft", frame_tick, 1'b1);
        run_to(2);
        chk("tear_new", seg, 7'h24);

        // Only digit 0 enabled, with its decimal point
        out_port0 = 32'h89ABCDEF;
        out_port1 = 32'h00000101;
        run_to(63);
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (m_pos < DIV && m_pos >= GRD) begin
                chk("solo_an", an, 8'hFE);
                chk("solo_dp", dp, 1'b0);
            end else begin
                chk("solo_off_an", an, 8'hFF);
                chk("solo_off_dp", dp, 1'b1);
            end
        end

        // Random port traffic over 10 frames
        for (int k = 0; k < 10 * FRAME; k++) begin
            if ($urandom_range(15) == 0) begin
                out_port0 = $urandom >> $urandom_range(31);
                out_port1 = $urandom;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
